// File: rtl/vec_mismatch_checker_pkg.sv
// Shared types and constants for the vector mismatch checker.
// Field slot indices map each tracker instance to its statistic.
package vec_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 16;
  localparam logic [CNT_W_DEF-1:0] FIRST_NONE = '1;

  // Tracker slots: aggregate first, then one per compared field.
  localparam int NUM_FLD = 4;
  localparam int FLD_ANY = 0;
  localparam int FLD_BW  = 1;
  localparam int FLD_LG  = 2;
  localparam int FLD_NT  = 3;

endpackage

// File: rtl/vec_mismatch_checker_if.sv
// Control, sample and statistics bundle for vec_mismatch_checker.
// master drives control/samples, slave is the checker itself.
interface vec_mismatch_checker_if
  import vec_chk_pkg::*;
#(
  parameter int W_BW  = 3,
  parameter int W_NT  = 6,
  parameter int CNT_W = CNT_W_DEF
);
  logic             start;
  logic             stop;
  logic             smp_valid;
  logic [W_BW-1:0]  ref_bw;
  logic [W_BW-1:0]  dut_bw;
  logic             ref_lg;
  logic             dut_lg;
  logic [W_NT-1:0]  ref_nt;
  logic [W_NT-1:0]  dut_nt;

  logic             busy;
  logic             done;
  logic             pass;
  logic             mismatch;
  logic [CNT_W-1:0] samples;
  logic [CNT_W-1:0] errors;
  logic [CNT_W-1:0] err_bw;
  logic [CNT_W-1:0] err_lg;
  logic [CNT_W-1:0] err_nt;
  logic [CNT_W-1:0] first_any;
  logic [CNT_W-1:0] first_bw;
  logic [CNT_W-1:0] first_lg;
  logic [CNT_W-1:0] first_nt;

  modport master (
    output start, stop, smp_valid, ref_bw, dut_bw, ref_lg, dut_lg, ref_nt, dut_nt,
    input  busy, done, pass, mismatch, samples, errors, err_bw, err_lg, err_nt,
           first_any, first_bw, first_lg, first_nt
  );

  modport slave (
    input  start, stop, smp_valid, ref_bw, dut_bw, ref_lg, dut_lg, ref_nt, dut_nt,
    output busy, done, pass, mismatch, samples, errors, err_bw, err_lg, err_nt,
           first_any, first_bw, first_lg, first_nt
  );

endinterface

// File: rtl/vec_field_tracker.sv
// Saturating mismatch counter plus timestamp of the first mismatch.
// first captures cyc only while the count is still zero.
module vec_field_tracker
  import vec_chk_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             hit,
  input  logic [CNT_W-1:0] cyc,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] first
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      first <= '1;
    end else if (clr) begin
      cnt   <= '0;
      first <= '1;
    end else if (hit) begin
      if (cnt != '1) cnt <= cnt + CNT_W'(1);
      if (cnt == '0) first <= cyc;
    end
  end

endmodule

// File: rtl/vec_mismatch_checker.sv
// Compares reference vs DUT fields per accepted sample during a run and
// keeps saturating per-field/aggregate error statistics with first-hit times.
module vec_mismatch_checker
  import vec_chk_pkg::*;
#(
  parameter int W_BW  = 3,
  parameter int W_NT  = 6,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst_n,
  vec_mismatch_checker_if.slave bus
);

  // cyc stops one short of all-ones so a timestamp never aliases "none".
  localparam logic [CNT_W-1:0] CYC_MAX = {{(CNT_W-1){1'b1}}, 1'b0};

  state_e state, state_nxt;

  logic                        accept;
  logic                        mis_bw, mis_lg, mis_nt, mis_any;
  logic [NUM_FLD-1:0]          hit;
  logic [NUM_FLD-1:0][CNT_W-1:0] cnt;
  logic [NUM_FLD-1:0][CNT_W-1:0] first;
  logic [CNT_W-1:0]            cyc;
  logic [CNT_W-1:0]            samples_q;
  logic                        busy_q, done_q, pass_q, mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // start beats stop; stop only matters while running.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN: begin
        if      (bus.start) state_nxt = ST_RUN;
        else if (bus.stop)  state_nxt = ST_DONE;
      end
      ST_DONE: if (bus.start) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept  = (state == ST_RUN) && bus.smp_valid && !bus.start;
  assign mis_bw  = |(bus.ref_bw ^ bus.dut_bw);
  assign mis_lg  = bus.ref_lg ^ bus.dut_lg;
  assign mis_nt  = |(bus.ref_nt ^ bus.dut_nt);
  assign mis_any = mis_bw | mis_lg | mis_nt;

  always_comb begin
    hit          = '0;
    hit[FLD_ANY] = accept & mis_any;
    hit[FLD_BW]  = accept & mis_bw;
    hit[FLD_LG]  = accept & mis_lg;
    hit[FLD_NT]  = accept & mis_nt;
  end

  vec_field_tracker #(.CNT_W(CNT_W)) u_trk [NUM_FLD-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.start),
    .hit   (hit),
    .cyc   (cyc),
    .cnt   (cnt),
    .first (first)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc       <= '0;
      samples_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      busy_q <= (state_nxt == ST_RUN);
      done_q <= (state_nxt == ST_DONE);
      pass_q <= (state_nxt == ST_DONE) && (cnt[FLD_ANY] == '0) && !hit[FLD_ANY];
      mis_q  <= hit[FLD_ANY];
      if (bus.start) begin
        cyc       <= '0;
        samples_q <= '0;
      end else begin
        if (state == ST_RUN && cyc != CYC_MAX) cyc <= cyc + CNT_W'(1);
        if (accept && samples_q != '1)         samples_q <= samples_q + CNT_W'(1);
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.mismatch  = mis_q;
  assign bus.samples   = samples_q;
  assign bus.errors    = cnt[FLD_ANY];
  assign bus.err_bw    = cnt[FLD_BW];
  assign bus.err_lg    = cnt[FLD_LG];
  assign bus.err_nt    = cnt[FLD_NT];
  assign bus.first_any = first[FLD_ANY];
  assign bus.first_bw  = first[FLD_BW];
  assign bus.first_lg  = first[FLD_LG];
  assign bus.first_nt  = first[FLD_NT];

endmodule

// File: doc/vec_mismatch_checker.md
VEC_MISMATCH_CHECKER -- requirements
Module: vec_mismatch_checker

Interface
REQ-001 Parameter W_BW, default 3: width of bitwise-OR field.
REQ-002 Parameter W_NT, default 6: width of NOT field.
REQ-003 Parameter CNT_W, default 16: width of every counter and timestamp.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  pulse: clear statistics, enter RUN.
REQ-007 stop  in  1  pulse: end run, enter DONE.
REQ-008 smp_valid  in  1  compare sample present this cycle.
REQ-009 ref_bw  in  W_BW  reference bitwise field.
REQ-010 dut_bw  in  W_BW  DUT bitwise field.
REQ-011 ref_lg  in  1  reference logical field.
REQ-012 dut_lg  in  1  DUT logical field.
REQ-013 ref_nt  in  W_NT  reference NOT field.
REQ-014 dut_nt  in  W_NT  DUT NOT field.
REQ-015 busy  out  1  high in RUN.
REQ-016 done  out  1  high in DONE.
REQ-017 pass  out  1  done and zero total errors.
REQ-018 mismatch  out  1  registered any-field mismatch of previous accepted sample.
REQ-019 samples  out  CNT_W  accepted sample count.
REQ-020 errors  out  CNT_W  samples with any field mismatched.
REQ-021 err_bw, err_lg, err_nt  out  CNT_W each  per-field mismatch counts.
REQ-022 first_any, first_bw, first_lg, first_nt  out  CNT_W each  cycle index of first mismatch; all-ones = none.

Function
REQ-023 FSM states IDLE, RUN, DONE; IDLE -start-> RUN; RUN -stop-> DONE; RUN or DONE -start-> RUN (restart); stop in IDLE/DONE ignored.
REQ-024 start and stop in same cycle: start wins.
REQ-025 On start: all counters zero, all first_* all-ones, mismatch 0, cycle index cyc 0; sample in the start cycle not accepted.
REQ-026 cyc increments every RUN cycle after the start cycle, saturating at all-ones minus one.
REQ-027 Sample accepted iff state RUN and smp_valid; sample coinciding with stop is accepted, then DONE.
REQ-028 Field mismatch = any bit of ref differs from dut for that field.
REQ-029 Accepted sample: samples+1; errors+1 if any field mismatched; each err_* +1 for its field.
REQ-030 first_* loads current cyc only when its matching count is zero at acceptance.
REQ-031 All counters saturate at all-ones; no wrap.
REQ-032 All outputs registered; effect of accepted sample visible exactly one cycle later.
REQ-033 mismatch cleared on any cycle without an accepted sample.
REQ-034 DONE holds all statistics stable until next start.

Reset
REQ-035 rst_n low: state IDLE; busy, done, pass, mismatch 0; counters 0; first_* all-ones; effective immediately, including mid-run.

Structure
REQ-036 Package vec_chk_pkg holds state enum, CNT_W default, FIRST_NONE (all-ones) constant.
REQ-037 Sub-module vec_field_tracker (saturating count + first-timestamp) instantiated once per field and once for aggregate.

Verification
REQ-038 Reset, start, 10 valid samples ref==dut, stop -> samples=10, errors=0, first_*=all-ones, pass=1.
REQ-039 Start; mismatch only dut_nt at cyc 3 and cyc 7 -> err_nt=2, first_nt=3, first_any=3, err_bw=err_lg=0, pass=0.
REQ-040 Single sample mismatching all three fields at cyc 5 -> errors=1, each err_*=1, all first_*=5, mismatch pulses one cycle.
REQ-041 CNT_W=4, 20 mismatching samples -> samples=errors=15 (saturated), no wrap.
REQ-042 start and stop asserted together during RUN -> state RUN, stats cleared; stop with smp_valid -> sample counted, done=1.
REQ-043 rst_n low mid-RUN with errors=4 -> immediately IDLE, errors=0, first_*=all-ones.
